csr_bank_timer: RTL and testbench



---
 rtl/csr_pkg.sv | 35 +++
 rtl/csr_scan_reg.sv | 39 +++
 rtl/csr_bank_timer.sv | 173 +++++++++++++++++
 tb/tb_csr_bank_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: STATUS_CTRL bit positions and register address offsets for csr_bank_timer.
// Offsets are functions of SEG_BYTES/CNT_BYTES so every parameterisation shares one map:
//   SEGEXE[0..S-1], IO_IN, IO_OUT, CNT[0..C-1], STATUS_CTRL, TEMP
package csr_pkg;

    localparam int ST_INT    = 0;
    localparam int ST_OVF    = 1;
    localparam int ST_CNT_EN = 2;
    localparam int ST_IE     = 3;

    function automatic int addr_io_in(input int seg_bytes);
        return seg_bytes;
    endfunction

    function automatic int addr_io_out(input int seg_bytes);
        return seg_bytes + 1;
    endfunction

    function automatic int addr_cnt0(input int seg_bytes);
        return seg_bytes + 2;
    endfunction

    function automatic int addr_status(input int seg_bytes, input int cnt_bytes);
        return seg_bytes + cnt_bytes + 2;
    endfunction

    function automatic int addr_temp(input int seg_bytes, input int cnt_bytes);
        return seg_bytes + cnt_bytes + 3;
    endfunction

    function automatic int num_regs(input int seg_bytes, input int cnt_bytes);
        return seg_bytes + cnt_bytes + 4;
    endfunction

endpackage

// File: rtl/csr_scan_reg.sv
// csr_scan_reg: one WIDTH-bit chain register. Synchronous reset beats scan shift,
// scan shift beats the functional load.
module csr_scan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_enable,
    input  logic             scan_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // next value: shift left with scan_in entering bit 0, else optional load
    always_comb begin
        data_d = data_q;
        if (scan_enable) begin
            data_d = {data_q[WIDTH-2:0], scan_in};
        end else if (load_en) begin
            data_d = load_val;
        end
    end

    // register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/csr_bank_timer.sv
// csr_bank_timer: parametrised CSR bank with live up-counter, overflow interrupt,
// sampled IO input register and one scan chain through every register.
// Optional feature macro: CSR_TIMER_EN (counter increments and hardware OVF/INT set).
// Without it the CNT bytes are plain storage, OVF reads 0 and INT is software-only.
module csr_bank_timer
    import csr_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int SEG_BYTES = 2,
    parameter  int CNT_BYTES = 2,
    localparam int N         = num_regs(SEG_BYTES, CNT_BYTES),
    localparam int ADDR_W    = $clog2(N),
    localparam int CW        = CNT_BYTES * WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       wr_enable,
    input  logic [WIDTH-1:0]           IO_IN,
    input  logic                       processor_enable,
    input  logic                       scan_enable,
    input  logic                       scan_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [SEG_BYTES*WIDTH-1:0] SEGEXE_OUT,
    output logic [WIDTH-1:0]           IO_OUT,
    output logic                       INT_OUT,
    output logic                       scan_out
);

    localparam int A_IO_IN  = addr_io_in(SEG_BYTES);
    localparam int A_IO_OUT = addr_io_out(SEG_BYTES);
    localparam int A_CNT0   = addr_cnt0(SEG_BYTES);
    localparam int A_STATUS = addr_status(SEG_BYTES, CNT_BYTES);
    localparam int A_TEMP   = addr_temp(SEG_BYTES, CNT_BYTES);

    function automatic logic addr_is(input logic [ADDR_W-1:0] a, input int idx);
        return a == ADDR_W'(idx);
    endfunction

    logic [WIDTH-1:0] reg_q    [N];
    logic [WIDTH-1:0] load_val [N];
    logic [N-1:0]     load_en;
    logic [N-1:0]     chain_in;
    logic             cnt_wr;
    logic [WIDTH-1:0] st_cur;
    logic [WIDTH-1:0] st_nxt;

    assign st_cur = reg_q[A_STATUS];

    // any write aimed at a counter byte suppresses that cycle's increment
    always_comb begin
        cnt_wr = 1'b0;
        for (int c = 0; c < CNT_BYTES; c++) begin
            if (wr_enable && addr_is(addr, A_CNT0 + c)) begin
                cnt_wr = 1'b1;
            end
        end
    end

`ifdef CSR_TIMER_EN
    logic [CW-1:0] cnt_cur;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_inc;
    logic          cnt_wrap;

    // counter view across bytes, increment qualifier and wrap detect
    always_comb begin
        cnt_cur = '0;
        for (int c = 0; c < CNT_BYTES; c++) begin
            cnt_cur[c*WIDTH +: WIDTH] = reg_q[A_CNT0 + c];
        end
        cnt_inc  = st_cur[ST_CNT_EN] && processor_enable && !cnt_wr;
        cnt_wrap = cnt_inc && (&cnt_cur);
        cnt_nxt  = cnt_cur + CW'(1);
    end
`endif

    // STATUS_CTRL next value: software write first, hardware flag set overrides
    always_comb begin
        st_nxt = st_cur;
        if (wr_enable && addr_is(addr, A_STATUS)) begin
            st_nxt         = data_in;
            st_nxt[ST_OVF] = st_cur[ST_OVF] & ~data_in[ST_OVF];
        end
`ifdef CSR_TIMER_EN
        if (cnt_wrap) begin
            st_nxt[ST_OVF] = 1'b1;
            if (st_cur[ST_IE]) begin
                st_nxt[ST_INT] = 1'b1;
            end
        end
`else
        st_nxt[ST_OVF] = 1'b0;
`endif
    end

    // per-register functional load enables and values
    always_comb begin
        load_en  = '0;
        load_val = reg_q;

        for (int s = 0; s < SEG_BYTES; s++) begin
            load_en[s]  = wr_enable && addr_is(addr, s);
            load_val[s] = data_in;
        end

        load_en[A_IO_IN]   = processor_enable;
        load_val[A_IO_IN]  = IO_IN;

        load_en[A_IO_OUT]  = wr_enable && addr_is(addr, A_IO_OUT);
        load_val[A_IO_OUT] = data_in;

        load_en[A_TEMP]    = wr_enable && addr_is(addr, A_TEMP);
        load_val[A_TEMP]   = data_in;

        for (int c = 0; c < CNT_BYTES; c++) begin
            load_en[A_CNT0 + c]  = wr_enable && addr_is(addr, A_CNT0 + c);
            load_val[A_CNT0 + c] = data_in;
        end
`ifdef CSR_TIMER_EN
        if (cnt_inc) begin
            for (int c = 0; c < CNT_BYTES; c++) begin
                load_en[A_CNT0 + c]  = 1'b1;
                load_val[A_CNT0 + c] = cnt_nxt[c*WIDTH +: WIDTH];
            end
        end
`endif

        load_en[A_STATUS]  = 1'b1;
        load_val[A_STATUS] = st_nxt;
    end

    // the register chain: register 0 takes scan_in, each later one the MSB of its predecessor
    for (genvar k = 0; k < N; k++) begin : g_reg
        if (k == 0) begin : g_head
            assign chain_in[k] = scan_in;
        end else begin : g_link
            assign chain_in[k] = reg_q[k-1][WIDTH-1];
        end

        csr_scan_reg #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk        (clk),
            .rst        (rst),
            .scan_enable(scan_enable),
            .scan_in    (chain_in[k]),
            .load_en    (load_en[k]),
            .load_val   (load_val[k]),
            .q          (reg_q[k])
        );
    end

    // combinational read mux; unmapped addresses read zero
    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            if (addr_is(addr, i)) begin
                data_out = reg_q[i];
            end
        end
    end

    for (genvar s = 0; s < SEG_BYTES; s++) begin : g_seg_out
        assign SEGEXE_OUT[s*WIDTH +: WIDTH] = reg_q[s];
    end

    assign IO_OUT   = reg_q[A_IO_OUT];
    assign INT_OUT  = st_cur[ST_INT];
    assign scan_out = reg_q[N-1][WIDTH-1];

endmodule

// File: tb/tb_csr_bank_timer.sv
// tb_csr_bank_timer: directed stimulus against a register-map model of the CSR bank,
// checked every cycle, plus literal expectations for the key scenarios.
module tb_csr_bank_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = '0;
    logic [7:0]  data_in = '0;
    logic        wr_enable = 1'b0;
    logic [7:0]  io_in = '0;
    logic        processor_enable = 1'b0;
    logic        scan_enable = 1'b0;
    logic        scan_in = 1'b0;
    logic [7:0]  data_out;
    logic [15:0] segexe_out;
    logic [7:0]  io_out;
    logic        int_out;
    logic        scan_out;

    int n_chk = 0;
    int n_err = 0;

    csr_bank_timer dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .data_in         (data_in),
        .wr_enable       (wr_enable),
        .IO_IN           (io_in),
        .processor_enable(processor_enable),
        .scan_enable     (scan_enable),
        .scan_in         (scan_in),
        .data_out        (data_out),
        .SEGEXE_OUT      (segexe_out),
        .IO_OUT          (io_out),
        .INT_OUT         (int_out),
        .scan_out        (scan_out)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m[0..1] SEGEXE, m[2] IO_IN, m[3] IO_OUT, m[4..5] CNT, m[6] STATUS, m[7] TEMP
    logic [7:0] m [8];
    bit         model_ok = 1'b0;

    always @(posedge clk) begin : model
        logic [63:0] ch;
        logic [7:0]  old [8];
        int          cnt;
        bit          cw;
        if (rst) begin
            for (int i = 0; i < 8; i++) m[i] = 8'h00;
            model_ok = 1'b1;
        end else if (scan_enable) begin
            for (int k = 0; k < 8; k++) ch[8*k +: 8] = m[k];
            ch = {ch[62:0], scan_in};
            for (int k = 0; k < 8; k++) m[k] = ch[8*k +: 8];
        end else begin
            old = m;
            if (processor_enable) m[2] = io_in;
            if (wr_enable) begin
                if (addr == 3'd6)
                    m[6] = {data_in[7:2], old[6][1] & ~data_in[1], data_in[0]};
                else if (addr != 3'd2)
                    m[addr] = data_in;
            end
            cw = wr_enable && (addr == 3'd4 || addr == 3'd5);
`ifdef CSR_TIMER_EN
            if (old[6][2] && processor_enable && !cw) begin
                cnt  = (int'(old[5]) * 256 + int'(old[4]) + 1) % 65536;
                m[4] = cnt[7:0];
                m[5] = cnt[15:8];
                if (cnt == 0) begin
                    m[6][1] = 1'b1;
                    if (old[6][3]) m[6][0] = 1'b1;
                end
            end
`else
            m[6][1] = 1'b0;
`endif
        end
    end

    // per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("cyc_data_out", data_out, m[addr]);
            chk("cyc_segexe", segexe_out, {m[1], m[0]});
            chk("cyc_io_out", io_out, m[3]);
            chk("cyc_int_out", int_out, m[6][0]);
            chk("cyc_scan_out", scan_out, m[7][7]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr      = a;
        data_in   = d;
        wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [7:0] exp, input string name);
        addr = a;
        #1;
        chk(name, data_out, exp);
    endtask

    logic [63:0] pat;
    logic [63:0] got;
    logic [7:0]  pat_b [8];

    initial begin
        pat   = 64'hDEAD_BEEF_0123_4567;
        pat_b = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        got   = '0;

        step();
        step();
        rst = 1'b0;

        // reset state
        for (int a = 0; a < 8; a++) read_chk(3'(a), 8'h00, "rst_read");
        chk("rst_int_out", int_out, 1'b0);
        chk("rst_scan_out", scan_out, 1'b0);

        // plain R/W registers; IO_IN not writable
        wr(3'd0, 8'hA5);
        wr(3'd3, 8'h3C);
        wr(3'd7, 8'h7E);
        wr(3'd2, 8'hFF);
        read_chk(3'd0, 8'hA5, "rw_segexe0");
        read_chk(3'd3, 8'h3C, "rw_io_out");
        read_chk(3'd7, 8'h7E, "rw_temp");
        read_chk(3'd2, 8'h00, "io_in_readonly");
        chk("segexe_out", segexe_out, 16'h00A5);
        chk("io_out", io_out, 8'h3C);

        // count FFFE -> FFFF -> 0000
        wr(3'd4, 8'hFE);
        wr(3'd5, 8'hFF);
        wr(3'd6, 8'h0C);
        processor_enable = 1'b1;
        step();
        step();
        processor_enable = 1'b0;
`ifdef CSR_TIMER_EN
        read_chk(3'd4, 8'h00, "wrap_cnt_lo");
        read_chk(3'd5, 8'h00, "wrap_cnt_hi");
        read_chk(3'd6, 8'h0F, "wrap_status");
        chk("wrap_int_out", int_out, 1'b1);
`else
        read_chk(3'd4, 8'hFE, "wrap_cnt_lo");
        read_chk(3'd5, 8'hFF, "wrap_cnt_hi");
        read_chk(3'd6, 8'h0C, "wrap_status");
        chk("wrap_int_out", int_out, 1'b0);
`endif
        wr(3'd6, 8'h0E);
        read_chk(3'd6, 8'h0C, "ovf_w1c");
        chk("int_cleared", int_out, 1'b0);

        // CNT writes suppress increment; all-ones write does not set OVF
        processor_enable = 1'b1;
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF);
        read_chk(3'd4, 8'hFF, "cntwr_lo");
        read_chk(3'd5, 8'hFF, "cntwr_hi");
        read_chk(3'd6, 8'h0C, "cntwr_no_ovf");

        // wrap coincident with STATUS write 0x02: hardware set wins
        wr(3'd6, 8'h02);
        processor_enable = 1'b0;
`ifdef CSR_TIMER_EN
        read_chk(3'd6, 8'h03, "hw_wins_status");
        read_chk(3'd4, 8'h00, "hw_wins_cnt");
        chk("hw_wins_int", int_out, 1'b1);
`else
        read_chk(3'd6, 8'h00, "hw_wins_status");
        read_chk(3'd4, 8'hFF, "hw_wins_cnt");
        chk("hw_wins_int", int_out, 1'b0);
`endif
        wr(3'd6, 8'h02);
        read_chk(3'd6, 8'h00, "status_cleared");

        // IO_IN sampling gated by processor_enable
        io_in = 8'h5A;
        step();
        read_chk(3'd2, 8'h00, "io_in_gated");
        processor_enable = 1'b1;
        step();
        processor_enable = 1'b0;
        read_chk(3'd2, 8'h5A, "io_in_sampled");

        // scan load: MSB of pattern first
        scan_enable = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            scan_in = pat[i];
            step();
        end
        for (int k = 0; k < 8; k++) read_chk(3'(k), pat_b[k], "scan_load_reg");

        // unload with counter enabled and sampling active: both must stay frozen
        processor_enable = 1'b1;
        io_in   = 8'hC3;
        scan_in = 1'b0;
        for (int i = 0; i < 64; i++) begin
            got[63-i] = scan_out;
            step();
        end
        processor_enable = 1'b0;
        chk("scan_unload", got, pat);

        // reset mid-scan, shifting resumes from zeros
        scan_in = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        read_chk(3'd0, 8'h00, "rst_mid_scan");
        chk("rst_mid_scan_out", scan_out, 1'b0);
        step();
        read_chk(3'd0, 8'h01, "scan_resume");
        scan_enable = 1'b0;
        scan_in     = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
